// File: rtl/qspline_pkg.sv
// -----------------------------------------------------------------------------
// qspline_pkg
// Shared definitions for the quadratic-spline Horner evaluator:
//   - default operand widths (T_W, C_W) and the full product width P_W
//   - the evaluator FSM state type
//   - sat_add(): C_W-bit addition returning {overflow, sum}, with optional
//     saturation at 2^C_W-1
// -----------------------------------------------------------------------------
package qspline_pkg;

  localparam int T_W = 10;
  localparam int C_W = 20;
  localparam int P_W = T_W + C_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL1 = 2'd1,
    MUL2 = 2'd2,
    HOLD = 2'd3
  } state_t;

  // Bit C_W of the result is the carry out of the raw addition. When sat_en
  // is set and the carry is out, the sum is clamped to all ones but the
  // overflow flag is still reported so the caller can raise out_sat.
  function automatic logic [C_W:0] sat_add(input logic [C_W-1:0] x,
                                           input logic [C_W-1:0] y,
                                           input logic           sat_en);
    logic [C_W:0] raw;
    raw = {1'b0, x} + {1'b0, y};
    if (raw[C_W] && sat_en) begin
      sat_add = {1'b1, {C_W{1'b1}}};
    end else begin
      sat_add = raw;
    end
  endfunction

endpackage

// File: rtl/qspline_mul_mul_10ns_20ns_30_1_1.sv
// -----------------------------------------------------------------------------
// qspline_mul_mul_10ns_20ns_30_1_1
// Shared unsigned multiplier, din0 x din1 -> dout. With NUM_STAGE=1 the
// product is purely combinational, so the caller must drive it from
// registered operands.
// Ports:
//   din0  in  din0_WIDTH  multiplicand (abscissa fraction)
//   din1  in  din1_WIDTH  multiplier (coefficient / partial sum)
//   dout  out dout_WIDTH  full-width unsigned product
// -----------------------------------------------------------------------------
module qspline_mul_mul_10ns_20ns_30_1_1 #(
  parameter int NUM_STAGE  = 1,
  parameter int din0_WIDTH = 10,
  parameter int din1_WIDTH = 20,
  parameter int dout_WIDTH = 30
) (
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  output logic [dout_WIDTH-1:0] dout
);

  // Only the single-stage (combinational) flavour exists in this library;
  // any other stage count yields a tied-off output.
  if (NUM_STAGE == 1) begin : g_comb
    assign dout = dout_WIDTH'(din0) * dout_WIDTH'(din1);
  end else begin : g_unsupported
    assign dout = '0;
  end

endmodule

// File: rtl/qspline_horner_eval.sv
// -----------------------------------------------------------------------------
// qspline_horner_eval
// Evaluates y = (a*t + b)*t + c for one unsigned Q0.T_W abscissa t and one
// coefficient set, sharing a single combinational multiplier over two cycles.
// Products are truncated (>> T_W). Each addition either saturates at
// 2^C_W-1 (SAT_EN=1) or wraps (SAT_EN=0); out_sat reports either event.
// Ports:
//   ap_clk     in   1    clock, rising edge
//   ap_rst_n   in   1    synchronous active-low reset
//   in_valid   in   1    {in_t, in_a, in_b, in_c} valid
//   in_ready   out  1    a sample is accepted this cycle if in_valid
//   in_t       in   T_W  abscissa fraction
//   in_a/b/c   in   C_W  spline coefficients
//   out_valid  out  1    out_y/out_sat valid (registered)
//   out_ready  in   1    sink accepts the result
//   out_y      out  C_W  result (registered)
//   out_sat    out  1    saturation/wrap seen in either addition (registered)
// -----------------------------------------------------------------------------
module qspline_horner_eval
  import qspline_pkg::*;
#(
  parameter int T_W    = qspline_pkg::T_W,
  parameter int C_W    = qspline_pkg::C_W,
  parameter bit SAT_EN = 1'b1
) (
  input  logic           ap_clk,
  input  logic           ap_rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [T_W-1:0] in_t,
  input  logic [C_W-1:0] in_a,
  input  logic [C_W-1:0] in_b,
  input  logic [C_W-1:0] in_c,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [C_W-1:0] out_y,
  output logic           out_sat
);

  state_t         state_r;
  state_t         next_state_s;

  logic [T_W-1:0] t_r;
  logic [C_W-1:0] a_r;
  logic [C_W-1:0] b_r;
  logic [C_W-1:0] c_r;
  logic [C_W-1:0] s1_r;
  logic           sat_r;
  logic [C_W-1:0] out_y_r;
  logic           out_sat_r;
  logic           out_valid_r;

  logic           in_ready_s;
  logic           accept_s;
  logic [C_W-1:0] mul_b_s;
  logic [C_W-1:0] addend_s;
  logic [P_W-1:0] p_s;
  logic [C_W:0]   add_s;
  logic           unused_p_lo_s;

  // Shared multiplier: t_r is always one operand; the other is a_r in MUL1
  // and the registered first-stage sum otherwise.
  qspline_mul_mul_10ns_20ns_30_1_1 #(
    .NUM_STAGE  (1),
    .din0_WIDTH (T_W),
    .din1_WIDTH (C_W),
    .dout_WIDTH (P_W)
  ) u_mul (
    .din0 (t_r),
    .din1 (mul_b_s),
    .dout (p_s)
  );

  // Truncating shift: the low T_W product bits are simply dropped.
  assign unused_p_lo_s = ^p_s[T_W-1:0];
  assign add_s         = sat_add(p_s[P_W-1:T_W], addend_s, SAT_EN);

  // Next-state, handshake and operand selection.
  always_comb begin
    next_state_s = state_r;
    in_ready_s   = 1'b0;
    mul_b_s      = s1_r;
    addend_s     = c_r;
    case (state_r)
      IDLE: begin
        in_ready_s = 1'b1;
        if (in_valid) begin
          next_state_s = MUL1;
        end else begin
          next_state_s = IDLE;
        end
      end
      MUL1: begin
        mul_b_s      = a_r;
        addend_s     = b_r;
        next_state_s = MUL2;
      end
      MUL2: begin
        next_state_s = HOLD;
      end
      HOLD: begin
        // Accepting the result frees the datapath in the same cycle, so a
        // waiting sample is captured without an IDLE bubble.
        in_ready_s = out_ready;
        if (!out_ready) begin
          next_state_s = HOLD;
        end else if (in_valid) begin
          next_state_s = MUL1;
        end else begin
          next_state_s = IDLE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
    accept_s = in_valid & in_ready_s;
  end

  // State, operand capture and the two accumulation stages.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_r     <= IDLE;
      t_r         <= '0;
      a_r         <= '0;
      b_r         <= '0;
      c_r         <= '0;
      s1_r        <= '0;
      sat_r       <= 1'b0;
      out_y_r     <= '0;
      out_sat_r   <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= next_state_s;
      out_valid_r <= (next_state_s == HOLD);
      if (accept_s) begin
        t_r <= in_t;
        a_r <= in_a;
        b_r <= in_b;
        c_r <= in_c;
      end
      if (state_r == MUL1) begin
        s1_r  <= add_s[C_W-1:0];
        sat_r <= add_s[C_W];
      end
      if (state_r == MUL2) begin
        out_y_r   <= add_s[C_W-1:0];
        out_sat_r <= sat_r | add_s[C_W];
      end
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign out_y     = out_y_r;
  assign out_sat   = out_sat_r;

endmodule

// File: tb/tb_qspline_horner_eval.sv
// -----------------------------------------------------------------------------
// tb_qspline_horner_eval
// Self-checking bench: two evaluators (saturating and wrapping) driven in
// lockstep, compared against an arithmetic reference of the spline formula.
// -----------------------------------------------------------------------------
module tb_qspline_horner_eval;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [9:0]  in_t;
  logic [19:0] in_a;
  logic [19:0] in_b;
  logic [19:0] in_c;

  logic        in_ready,   in_ready_w;
  logic        out_valid,  out_valid_w;
  logic [19:0] out_y,      out_y_w;
  logic        out_sat,    out_sat_w;

  int checks = 0;
  int errors = 0;

  qspline_horner_eval #(.T_W(10), .C_W(20), .SAT_EN(1'b1)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_t(in_t), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_sat(out_sat)
  );

  qspline_horner_eval #(.T_W(10), .C_W(20), .SAT_EN(1'b0)) dut_wrap (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
    .in_valid(in_valid), .in_ready(in_ready_w),
    .in_t(in_t), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .out_valid(out_valid_w), .out_ready(out_ready),
    .out_y(out_y_w), .out_sat(out_sat_w)
  );

  always #5 ap_clk = ~ap_clk;

  initial begin
    #300000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic of y = ((a*t)>>10 + b)*t >> 10 + c.
  function automatic logic [20:0] ref_eval(input logic [9:0] t, input logic [19:0] a,
                                           input logic [19:0] b, input logic [19:0] c,
                                           input bit sat_en);
    longint unsigned max_v, lt, s, y;
    bit ov1, ov2;
    max_v = 64'd1048575;
    lt    = longint'(t);
    s     = (lt * longint'(a)) / 64'd1024 + longint'(b);
    ov1   = (s > max_v);
    if (ov1) s = sat_en ? max_v : s - 64'd1048576;
    y     = (lt * s) / 64'd1024 + longint'(c);
    ov2   = (y > max_v);
    if (ov2) y = sat_en ? max_v : y - 64'd1048576;
    return {ov1 | ov2, y[19:0]};
  endfunction

  task automatic check_result(input string tag, input logic [9:0] t, input logic [19:0] a,
                              input logic [19:0] b, input logic [19:0] c);
    logic [20:0] e1, e0;
    e1 = ref_eval(t, a, b, c, 1'b1);
    e0 = ref_eval(t, a, b, c, 1'b0);
    check_val({tag, "_y"},        out_y,     e1[19:0]);
    check_val({tag, "_sat"},      out_sat,   e1[20]);
    check_val({tag, "_y_wrap"},   out_y_w,   e0[19:0]);
    check_val({tag, "_sat_wrap"}, out_sat_w, e0[20]);
  endtask

  // One sample from IDLE: accepted at the next edge, result after two more.
  task automatic run_one(input string tag, input logic [9:0] t, input logic [19:0] a,
                         input logic [19:0] b, input logic [19:0] c);
    @(negedge ap_clk);
    in_t = t; in_a = a; in_b = b; in_c = c;
    in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check_val({tag, "_in_ready"}, in_ready, 1);
    @(posedge ap_clk);
    #1 in_valid = 1'b0;
    @(negedge ap_clk);
    check_val({tag, "_valid_mul1"}, out_valid, 0);
    @(negedge ap_clk);
    check_val({tag, "_valid_mul2"}, out_valid, 0);
    @(negedge ap_clk);
    check_val({tag, "_valid_hold"}, out_valid, 1);
    check_val({tag, "_valid_wrap"}, out_valid_w, 1);
    check_result(tag, t, a, b, c);
  endtask

  logic [9:0]  st [8];
  logic [19:0] sa [8], sb [8], sc [8];
  logic [20:0] exp_q [$];
  logic [20:0] expw_q [$];

  initial begin
    ap_rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_t = '0; in_a = '0; in_b = '0; in_c = '0;
    repeat (3) @(posedge ap_clk);
    @(negedge ap_clk);
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_out_y",     out_y, 0);
    check_val("rst_out_sat",   out_sat, 0);
    check_val("rst_in_ready",  in_ready, 1);
    ap_rst_n = 1'b1;

    // Directed corners.
    run_one("nominal", 10'd512, 20'd4096, 20'd1000, 20'd7);
    check_val("nominal_const_y", out_y, 1531);
    run_one("zero_t", 10'd0, 20'hFFFFF, 20'hFFFFF, 20'd12345);
    check_val("zero_t_const_y", out_y, 12345);
    run_one("saturate", 10'd1023, 20'hFFFFF, 20'hFFFFF, 20'hFFFFF);
    check_val("saturate_const_y", out_y, 20'hFFFFF);
    check_val("saturate_const_sat", out_sat, 1);
    for (int i = 0; i < 3; i++) begin
      run_one("random", 10'($urandom), 20'($urandom), 20'($urandom), 20'($urandom));
    end

    // Backpressure followed by a back-to-back accept.
    begin
      logic [9:0]  t_a, t_b;
      logic [19:0] a_a, b_a, c_a, a_b, b_b, c_b;
      logic [20:0] ea;
      bit seen;
      t_a = 10'($urandom); a_a = 20'($urandom); b_a = 20'($urandom); c_a = 20'($urandom);
      t_b = 10'($urandom); a_b = 20'($urandom); b_b = 20'($urandom); c_b = 20'($urandom);
      ea = ref_eval(t_a, a_a, b_a, c_a, 1'b1);
      @(negedge ap_clk);
      in_t = t_a; in_a = a_a; in_b = b_a; in_c = c_a;
      in_valid = 1'b1; out_ready = 1'b0;
      @(posedge ap_clk);
      #1;
      // Sample B is offered while the evaluator is busy and must be ignored.
      in_t = t_b; in_a = a_b; in_b = b_b; in_c = c_b;
      seen = 1'b0;
      for (int k = 0; k < 10 && !seen; k++) begin
        @(negedge ap_clk);
        if (out_valid) seen = 1'b1;
      end
      check_val("bp_valid_seen", seen, 1);
      for (int k = 0; k < 10; k++) begin
        @(negedge ap_clk);
        check_val("bp_valid_held", out_valid, 1);
        check_val("bp_y_stable",   out_y, ea[19:0]);
        check_val("bp_in_ready",   in_ready, 0);
      end
      @(negedge ap_clk);
      out_ready = 1'b1;
      #1;
      check_val("b2b_in_ready", in_ready, 1);
      @(posedge ap_clk);
      #1 in_valid = 1'b0;
      @(negedge ap_clk);
      check_val("b2b_valid_drop", out_valid, 0);
      @(negedge ap_clk);
      check_val("b2b_valid_mul2", out_valid, 0);
      @(negedge ap_clk);
      check_val("b2b_valid_hold", out_valid, 1);
      check_result("b2b", t_b, a_b, b_b, c_b);
    end

    // Streaming: 8 random samples, both handshakes held high.
    repeat (2) @(posedge ap_clk);
    for (int i = 0; i < 8; i++) begin
      st[i] = 10'($urandom); sa[i] = 20'($urandom); sb[i] = 20'($urandom); sc[i] = 20'($urandom);
    end
    st[3] = 10'd1023; sa[3] = 20'hFFFF0; sb[3] = 20'hF0000; sc[3] = 20'h80000;
    #1;
    in_t = st[0]; in_a = sa[0]; in_b = sb[0]; in_c = sc[0];
    in_valid = 1'b1; out_ready = 1'b1;
    begin
      int idx, got, cyc, last;
      bit take;
      logic [20:0] e;
      idx = 0; got = 0; cyc = 0; last = -1;
      while (got < 8 && cyc < 200) begin
        @(negedge ap_clk);
        cyc++;
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            check_val("stream_unexpected", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check_val("stream_y",   out_y,   e[19:0]);
            check_val("stream_sat", out_sat, e[20]);
            e = expw_q.pop_front();
            check_val("stream_y_wrap", out_y_w, e[19:0]);
          end
          if (last >= 0) check_val("stream_gap", cyc - last, 3);
          last = cyc;
          got++;
        end
        take = in_valid && in_ready;
        if (take) begin
          exp_q.push_back(ref_eval(st[idx], sa[idx], sb[idx], sc[idx], 1'b1));
          expw_q.push_back(ref_eval(st[idx], sa[idx], sb[idx], sc[idx], 1'b0));
        end
        @(posedge ap_clk);
        #1;
        if (take) begin
          idx++;
          if (idx < 8) begin
            in_t = st[idx]; in_a = sa[idx]; in_b = sb[idx]; in_c = sc[idx];
          end else begin
            in_valid = 1'b0;
          end
        end
      end
      check_val("stream_count", got, 8);
    end

    // Reset taken in MUL2 abandons the sample.
    repeat (2) @(posedge ap_clk);
    begin
      int vc;
      @(negedge ap_clk);
      in_t = 10'd700; in_a = 20'd300000; in_b = 20'd5000; in_c = 20'd99;
      in_valid = 1'b1; out_ready = 1'b1;
      @(posedge ap_clk);
      #1 in_valid = 1'b0;
      @(posedge ap_clk);
      @(negedge ap_clk);
      ap_rst_n = 1'b0;
      @(negedge ap_clk);
      check_val("midrst_out_valid", out_valid, 0);
      check_val("midrst_in_ready",  in_ready, 1);
      check_val("midrst_out_y",     out_y, 0);
      check_val("midrst_out_sat",   out_sat, 0);
      ap_rst_n = 1'b1;
      vc = 0;
      for (int k = 0; k < 8; k++) begin
        @(negedge ap_clk);
        if (out_valid) vc++;
      end
      check_val("midrst_no_output", vc, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
